// File: rtl/riscv_pkg.sv
// Shared decode definitions: opcodes, control-bit positions, the decoded
// instruction bundle and the issue-slot state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam int unsigned CTRL_REGWRITE   = 7;
    localparam int unsigned CTRL_ALUSRC     = 6;
    localparam int unsigned CTRL_MEMTOREG   = 5;
    localparam int unsigned CTRL_MEMRE      = 4;
    localparam int unsigned CTRL_MEMWR      = 3;
    localparam int unsigned CTRL_BYTEORWORD = 2;
    localparam int unsigned CTRL_ALUOP_MSB  = 1;
    localparam int unsigned CTRL_ALUOP_LSB  = 0;

    localparam int unsigned REG_IDX_W = 5;

    // Decoded instruction bundle, identical on the decode and issue sides.
    typedef struct packed {
        logic [6:0]           opcode;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [31:0]          imm;
        logic [7:0]           ctrls;
    } instr_t;

    typedef enum logic [1:0] {
        StEmpty,
        StStall,
        StReady
    } iss_state_e;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_LOAD) ||
               (opcode == OP_ITYPE) || (opcode == OP_STORE);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/sb_counters.sv
// Per-register in-flight write counters. Register 0 never counts.
module sb_counters
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic [REG_IDX_W-1:0] inc_rd,
    input  logic                 dec,
    input  logic [REG_IDX_W-1:0] dec_rd,
    output logic [NUM_REGS-1:0]  busy,
    output logic [NUM_REGS-1:0]  at_max
);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    // Next counts: a matching inc and dec in one cycle cancel out.
    always_comb begin
        cnt_d[0] = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            unique case ({inc && (inc_rd == REG_IDX_W'(i)), dec && (dec_rd == REG_IDX_W'(i))})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Status vectors consumed by the hazard check.
    always_comb begin
        busy   = '0;
        at_max = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy[i]   = (cnt_q[i] != '0);
            at_max[i] = (cnt_q[i] == '1);
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue stage: one-entry issue register guarded by a per-register
// write scoreboard that blocks RAW and WAW hazards until writeback.
module issue_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned STALL_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [6:0]         dec_opcode,
    input  logic [4:0]         dec_rd,
    input  logic [4:0]         dec_rs1,
    input  logic [4:0]         dec_rs2,
    input  logic [2:0]         dec_funct3,
    input  logic [6:0]         dec_funct7,
    input  logic [31:0]        dec_imm,
    input  logic [7:0]         dec_ctrls,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [6:0]         iss_opcode,
    output logic [4:0]         iss_rd,
    output logic [4:0]         iss_rs1,
    output logic [4:0]         iss_rs2,
    output logic [2:0]         iss_funct3,
    output logic [6:0]         iss_funct7,
    output logic [31:0]        iss_imm,
    output logic [7:0]         iss_ctrls,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    input  logic               flush,
    output logic [STALL_W-1:0] stall_cycles,
    output logic               sb_err
);

    instr_t              dec_ins;
    instr_t              entry_q;
    logic                held_q;
    iss_state_e          state;
    logic                raw1, raw2, waw, hazard;
    logic                iss_hs, dec_acc;
    logic                cnt_inc, cnt_dec, wb_live;
    logic [NUM_REGS-1:0] busy, at_max;
    logic [STALL_W-1:0]  stall_q;
    logic                err_q;

    assign dec_ins = {dec_opcode, dec_rd, dec_rs1, dec_rs2,
                      dec_funct3, dec_funct7, dec_imm, dec_ctrls};

    // Hazard check and slot state, from registered entry and counters only.
    always_comb begin
        raw1   = uses_rs1(entry_q.opcode) && (entry_q.rs1 != '0) && busy[entry_q.rs1];
        raw2   = uses_rs2(entry_q.opcode) && (entry_q.rs2 != '0) && busy[entry_q.rs2];
        waw    = entry_q.ctrls[CTRL_REGWRITE] && (entry_q.rd != '0) && at_max[entry_q.rd];
        hazard = held_q && (raw1 || raw2 || waw);
        if (!held_q) begin
            state = StEmpty;
        end else if (hazard) begin
            state = StStall;
        end else begin
            state = StReady;
        end
    end

    // Handshakes; flush blocks both sides for the cycle.
    always_comb begin
        iss_valid = (state == StReady) && !flush;
        iss_hs    = iss_valid && iss_ready;
        dec_ready = !flush && (!held_q || iss_hs);
        dec_acc   = dec_valid && dec_ready;
        cnt_inc   = iss_hs && entry_q.ctrls[CTRL_REGWRITE] && (entry_q.rd != '0);
        wb_live   = wb_valid && (wb_rd != '0);
        cnt_dec   = wb_live && busy[wb_rd];
    end

    sb_counters #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_counters (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (cnt_inc),
        .inc_rd (entry_q.rd),
        .dec    (cnt_dec),
        .dec_rd (wb_rd),
        .busy   (busy),
        .at_max (at_max)
    );

    // Issue register: load on accept, clear on flush or drain; zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q  <= 1'b0;
            entry_q <= '0;
        end else if (flush) begin
            held_q  <= 1'b0;
            entry_q <= '0;
        end else if (dec_acc) begin
            held_q  <= 1'b1;
            entry_q <= dec_ins;
        end else if (iss_hs) begin
            held_q  <= 1'b0;
            entry_q <= '0;
        end
    end

    // Saturating stall counter and sticky writeback-underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state == StStall) && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_W'(1);
            end
            if (wb_live && !busy[wb_rd]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign sb_err       = err_q;
    assign iss_opcode   = entry_q.opcode;
    assign iss_rd       = entry_q.rd;
    assign iss_rs1      = entry_q.rs1;
    assign iss_rs2      = entry_q.rs2;
    assign iss_funct3   = entry_q.funct3;
    assign iss_funct7   = entry_q.funct7;
    assign iss_imm      = entry_q.imm;
    assign iss_ctrls    = entry_q.ctrls;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
In-order issue controller between the decode stage and execute/memory.
- Holds one decoded instruction in an issue register.
- Tracks outstanding register writes in a per-register scoreboard.
- Stalls on RAW and WAW hazards until writeback clears them.
- Uses valid/ready handshakes on both sides, so decode and execute can stall independently.

Parameters:
NUM_REGS, 32, architectural integer registers (x0 hardwired zero)
CNT_W, 2, width of per-register in-flight write counter (max 3 outstanding writes per rd)
STALL_W, 16, width of saturating hazard-stall cycle counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decode presents an instruction
dec_ready  out  1  issue register can accept this cycle
dec_opcode  in  7  decoded opcode
dec_rd/dec_rs1/dec_rs2  in  5 each  register indices
dec_funct3  in  3  funct3
dec_funct7  in  7  funct7
dec_imm  in  32  sign-extended immediate
dec_ctrls  in  8  control bits: [7] REGWRITE, [6] ALUSRC, [5] MEMTOREG, [4] MEMRE, [3] MEMWR, [2] BYTEORWORD, [1:0] ALUOP
iss_valid  out  1  held instruction is hazard-free and offered to execute
iss_ready  in  1  execute accepts
iss_opcode, iss_rd, iss_rs1, iss_rs2, iss_funct3, iss_funct7, iss_imm, iss_ctrls  out  as dec_*  registered copy of the held instruction
wb_valid  in  1  a register write retires this cycle
wb_rd  in  5  destination being written back
flush  in  1  discard the held instruction
stall_cycles  out  STALL_W  saturating count of hazard-stalled cycles
sb_err  out  1  sticky: writeback to a register with zero in-flight count

Behaviour:
- Reset (async, rst_n=0): issue register invalid, all iss_* = 0, every scoreboard counter = 0, stall_cycles = 0, sb_err = 0. Deassertion takes effect on the next clk edge.
- FSM state derived from the held entry:
  - EMPTY: no entry held.
  - STALL: entry held, hazard=1.
  - READY: entry held, hazard=0.
  - Transitions:
    - EMPTY→(STALL|READY) on dec_valid.
    - READY→EMPTY on an iss handshake with no new dec.
    - READY→(STALL|READY) on an iss handshake with a simultaneous dec accept.
    - STALL→READY when the hazard clears.
    - Any state→EMPTY on flush.
- dec_ready = !held || (iss_valid && iss_ready). Combinational; this gives full throughput with back-to-back issue.
- iss_valid = held && !hazard. Depends only on registered state.
- Source usage:
  - rs1 used for opcodes 0110011, 0000011, 0010011, 0100011.
  - rs2 used for 0110011 and 0100011.
  - LUI (0110111) and unknown opcodes use neither.
  - Index 0 never hazards.
- hazard = (rs1 used && cnt[rs1]≠0) || (rs2 used && cnt[rs2]≠0) || (REGWRITE && rd≠0 && cnt[rd]==max).
- Scoreboard update at clk edge:
  - inc = iss handshake && REGWRITE && rd≠0.
  - dec = wb_valid && wb_rd≠0 && cnt[wb_rd]≠0.
  - inc and dec on the same register in the same cycle: counter unchanged.
  - x0 counter is always 0.
- No writeback bypass: hazard uses the registered counters, so a consumer issues at the earliest one cycle after the clearing wb_valid.
- wb_valid to a register with cnt==0 (rd≠0): no counter change, sb_err←1. sb_err is sticky until reset.
- flush:
  - Invalidates the held entry.
  - dec_ready is forced 0 that cycle; a flush-cycle dec is dropped.
  - No issue occurs that cycle (iss_valid forced 0).
  - Scoreboard is untouched, since in-flight writes still retire; wb in the flush cycle is still processed.
- stall_cycles increments each cycle state==STALL and saturates at 2^STALL_W−1.
- iss_* hold their values while !iss_ready, and are zero when EMPTY.
- Latency: decode→issue is 1 cycle minimum (registered).

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants: OP_RTYPE, OP_LOAD, OP_ITYPE, OP_STORE, OP_LUI.
  - Ctrl bit indices: CTRL_REGWRITE=7 … CTRL_ALUOP_LSB=0.
  - A packed struct for the decoded-instruction bundle, shared by dec_* and iss_*.
- One sub-module, sb_counters: the NUM_REGS×CNT_W counter array.
  - Inputs: inc/inc_rd, dec/dec_rd.
  - Outputs: the per-register busy vector and the at-max vector.

Test Plan:
- Reset, then ADD x3,x1,x2 with iss_ready=1 → iss_valid at cycle 1, cnt[3]=1, dec_ready stays 1.
- LW x5 issued, then ADD x6,x5,x0 → stalls (stall_cycles increments), iss_valid=0 until wb_valid/wb_rd=5; issues in the cycle after wb.
- Four back-to-back ADDI x7 writes with no wb → the fourth stalls on WAW (cnt[7]=3); a wb to 7 releases it.
- Same cycle: issue ADD x4 (REGWRITE) and wb_rd=4, with cnt[4]=1 beforehand → cnt[4] remains 1.
- ADD x2,x8,x9 held with iss_ready=0, then flush → entry dropped, iss_valid=0, cnt unchanged, and a dec presented in the flush cycle is not accepted.
- wb_valid with wb_rd=9 and cnt[9]=0 → sb_err=1 and stays 1. Separately, ADD x0 issued → cnt[0] remains 0, and rs=x0 never stalls.
